imem_dmem_arbiter: RTL and testbench

- Shares one single-port unified RAM between the pipeline's instruction-fetch (IF) port and its data-memory (MEM-stage) port. This replaces separate instruction and data memories.
- Accepts level-held requests from both ports, arbitrates between them, and issues exactly one registered RAM access per grant.
- Waits a fixed RAM latency, then returns data with a one-cycle ready pulse.
- Produces per-port stall signals that the hazard logic uses to freeze pipeline stages.

---
 rtl/imem_dmem_arbiter.sv | 114 +++++++++++
 tb/tb_imem_dmem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port RAM between the IF and MEM ports.
// MEM wins ties unless IF has been starved for STARVE_MAX grants.
`timescale 1ns/1ps
module imem_dmem_arbiter #(
  parameter int RAM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_dmtype,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [2:0]  ram_dmtype,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [2:0] LAT1 = 3'(RAM_LAT - 1);

  state_t     state, next;
  logic [2:0] cnt;
  logic [3:0] starve;
  logic       owner;
  logic       gnt_if, gnt_mem;
  logic       done;

  always_comb begin
    next    = state;
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_req && (!if_req || starve != SMAX))
          gnt_mem = 1'b1;
        else if (if_req)
          gnt_if = 1'b1;
        if (gnt_if || gnt_mem)
          next = ISSUE;
      end
      ISSUE: next = (RAM_LAT == 1) ? DONE : WAIT;
      WAIT:  if (cnt == 3'd1) next = DONE;
      DONE:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      starve     <= '0;
      owner      <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_dmtype <= '0;
    end else begin
      state  <= next;
      ram_en <= gnt_if | gnt_mem;
      ram_we <= gnt_mem & mem_we;
      if (gnt_mem) begin
        owner      <= 1'b1;
        ram_addr   <= mem_addr;
        ram_wdata  <= mem_wdata;
        ram_dmtype <= mem_dmtype;
      end else if (gnt_if) begin
        owner      <= 1'b0;
        ram_addr   <= if_addr;
        ram_wdata  <= '0;
        ram_dmtype <= 3'b010;
      end
      if (state == ISSUE)
        cnt <= LAT1;
      else if (state == WAIT)
        cnt <= cnt - 3'd1;
      // IF forced through once MEM has won STARVE_MAX times in a row
      if (gnt_mem && if_req)
        starve <= (starve == SMAX) ? starve : starve + 4'd1;
      else if (gnt_if || gnt_mem)
        starve <= '0;
    end
  end

  assign done      = (state == DONE);
  assign if_ready  = done & ~owner;
  assign mem_ready = done & owner;
  assign if_rdata  = if_ready ? ram_rdata : '0;
  assign mem_rdata = mem_ready ? ram_rdata : '0;
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: RAM_LAT=2 main instance,
// plus a RAM_LAT=1 instance for the short-latency path.
`timescale 1ns/1ps
module tb_imem_dmem_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        if_req = 0, mem_req = 0, mem_we = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
  logic [2:0]  mem_dmtype = 0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ready, if_stall, mem_ready, mem_stall, ram_en, ram_we;
  logic [2:0]  ram_dmtype;

  logic        mem_req1 = 0;
  logic [31:0] mem_addr1 = 0;
  logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
  logic        if_ready1, if_stall1, mem_ready1, mem_stall1, ram_en1, ram_we1;
  logic [2:0]  ram_dmtype1;

  imem_dmem_arbiter #(.RAM_LAT(2), .STARVE_MAX(2)) u0 (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_dmtype(mem_dmtype),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_dmtype(ram_dmtype), .ram_rdata(ram_rdata)
  );

  imem_dmem_arbiter #(.RAM_LAT(1), .STARVE_MAX(2)) u1 (
    .clk(clk), .rstn(rstn),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(if_rdata1),
    .if_ready(if_ready1), .if_stall(if_stall1),
    .mem_req(mem_req1), .mem_we(1'b0), .mem_addr(mem_addr1),
    .mem_wdata(32'h0), .mem_dmtype(3'b010),
    .mem_rdata(mem_rdata1), .mem_ready(mem_ready1), .mem_stall(mem_stall1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_dmtype(ram_dmtype1), .ram_rdata(ram_rdata1)
  );

  // RAM model: preset words, written words, else ~addr
  logic [31:0]  wr [256];
  logic [255:0] wv = '0;
  logic [31:0]  d0 = 0, d1 = 0, d10 = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (wv[a[9:2]]) return wr[a[9:2]];
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      32'h10:  return 32'h0051_0113;
      32'h200: return 32'h1234_5678;
      default: return ~a;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      d0 <= rd(ram_addr);
      if (ram_we) begin
        wr[ram_addr[9:2]] <= ram_wdata;
        wv[ram_addr[9:2]] <= 1'b1;
      end
    end
    d1 <= d0;
    if (ram_en1) d10 <= rd(ram_addr1);
  end
  assign ram_rdata  = d1;
  assign ram_rdata1 = d10;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  dm;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic        port;
    logic        chkd;
    logic [31:0] data;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  gnt_t g;
  rsp_t r;

  task automatic push_g(input int c, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic [2:0] dm);
    gnt_t x;
    x.cyc = c; x.addr = a; x.we = we; x.wdata = wd; x.dm = dm;
    gq.push_back(x);
  endtask

  task automatic push_r(input int c, input logic p, input logic ck,
                        input logic [31:0] d);
    rsp_t x;
    x.cyc = c; x.port = p; x.chkd = ck; x.data = d;
    rq.push_back(x);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (ram_en) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          g = gq.pop_front();
          chk("gnt_cyc", 32'(cyc), 32'(g.cyc));
          chk("gnt_addr", ram_addr, g.addr);
          chk("gnt_we", 32'(ram_we), 32'(g.we));
          chk("gnt_dm", 32'(ram_dmtype), 32'(g.dm));
          if (g.we) chk("gnt_wdata", ram_wdata, g.wdata);
        end
      end
      if (if_ready || mem_ready) begin
        chk("rdy_excl", 32'(if_ready & mem_ready), 32'h0);
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          r = rq.pop_front();
          chk("rsp_cyc", 32'(cyc), 32'(r.cyc));
          chk("rsp_port", 32'(mem_ready), 32'(r.port));
          if (r.chkd)
            chk("rsp_data", mem_ready ? mem_rdata : if_rdata, r.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input logic port);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (port ? mem_ready : if_ready) return;
    end
    chk("rdy_timeout", 32'(port), 32'hFFFF_FFFF);
  endtask

  task automatic if_do(input logic [31:0] a);
    if_addr = a;
    if_req  = 1'b1;
    wait_rdy(1'b0);
    tick();
    if_req = 1'b0;
  endtask

  task automatic mem_do(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] dm);
    mem_we = we; mem_addr = a; mem_wdata = wd; mem_dmtype = dm;
    mem_req = 1'b1;
    wait_rdy(1'b1);
    tick();
    mem_req = 1'b0;
  endtask

  int t;

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_dm", 32'(ram_dmtype), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    // single IF read
    tick();
    t = cyc;
    push_g(t + 1, 32'h10, 0, 0, 3'b010);
    push_r(t + 3, 0, 1, 32'h0051_0113);
    if_addr = 32'h10;
    if_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("if_stall", 32'(if_stall), 1);
    end
    wait_rdy(1'b0);
    chk("if_stall_rdy", 32'(if_stall), 0);
    tick();
    if_req = 1'b0;

    // MEM store with IF pending, then read back
    tick();
    t = cyc;
    push_g(t + 1, 32'h100, 1, 32'hDEAD_BEEF, 3'b010);
    push_g(t + 5, 32'h20, 0, 0, 3'b010);
    push_r(t + 3, 1, 0, 0);
    push_r(t + 7, 0, 1, 32'hFFFF_FFDF);
    fork
      mem_do(1, 32'h100, 32'hDEAD_BEEF, 3'b010);
      if_do(32'h20);
    join
    tick();
    t = cyc;
    push_g(t + 1, 32'h100, 0, 0, 3'b100);
    push_r(t + 3, 1, 1, 32'hDEAD_BEEF);
    mem_do(0, 32'h100, 0, 3'b100);

    // starvation: MEM, MEM, IF, MEM, MEM, IF
    tick();
    t = cyc;
    push_g(t + 1,  32'h300, 0, 0, 3'b010);
    push_g(t + 5,  32'h304, 0, 0, 3'b010);
    push_g(t + 9,  32'h40,  0, 0, 3'b010);
    push_g(t + 13, 32'h308, 0, 0, 3'b010);
    push_g(t + 17, 32'h30C, 0, 0, 3'b010);
    push_g(t + 21, 32'h44,  0, 0, 3'b010);
    push_r(t + 3,  1, 1, 32'hFFFF_FCFF);
    push_r(t + 7,  1, 1, 32'hFFFF_FCFB);
    push_r(t + 11, 0, 1, 32'hFFFF_FFBF);
    push_r(t + 15, 1, 1, 32'hFFFF_FCF7);
    push_r(t + 19, 1, 1, 32'hFFFF_FCF3);
    push_r(t + 23, 0, 1, 32'hFFFF_FFBB);
    fork
      begin
        mem_do(0, 32'h300, 0, 3'b010);
        mem_do(0, 32'h304, 0, 3'b010);
        mem_do(0, 32'h308, 0, 3'b010);
        mem_do(0, 32'h30C, 0, 3'b010);
      end
      begin
        if_do(32'h40);
        if_do(32'h44);
      end
    join

    // RAM_LAT=1 load on u1
    tick();
    t = cyc;
    mem_addr1 = 32'h200;
    mem_req1  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l1_en", 32'(ram_en1), 32'(cyc == t + 1));
      chk("l1_rdy", 32'(mem_ready1), 32'(cyc == t + 2));
      if (cyc == t + 1) chk("l1_addr", ram_addr1, 32'h200);
      if (cyc == t + 2) chk("l1_data", mem_rdata1, 32'h1234_5678);
    end
    tick();
    mem_req1 = 1'b0;
    @(negedge clk);
    chk("l1_idle_en", 32'(ram_en1), 0);
    chk("l1_idle_rdy", 32'(mem_ready1 | if_ready1), 0);

    // reset during WAIT of a MEM store
    tick();
    t = cyc;
    push_g(t + 1, 32'h180, 1, 32'hCAFE_F00D, 3'b001);
    mem_we = 1; mem_addr = 32'h180; mem_wdata = 32'hCAFE_F00D;
    mem_dmtype = 3'b001;
    mem_req = 1'b1;
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("rr_ram_en", 32'(ram_en), 0);
    chk("rr_ram_we", 32'(ram_we), 0);
    chk("rr_ready", 32'(if_ready | mem_ready), 0);
    chk("rr_ram_addr", ram_addr, 0);
    mem_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    t = cyc;
    push_g(t + 1, 32'h8C, 0, 0, 3'b010);
    push_r(t + 3, 0, 1, 32'hFFFF_FF73);
    if_do(32'h8C);

    // back-to-back IF fetches
    tick();
    t = cyc;
    push_g(t + 1, 32'h0, 0, 0, 3'b010);
    push_g(t + 5, 32'h4, 0, 0, 3'b010);
    push_g(t + 9, 32'h8, 0, 0, 3'b010);
    push_r(t + 3,  0, 1, 32'h0000_0013);
    push_r(t + 7,  0, 1, 32'h0010_0093);
    push_r(t + 11, 0, 1, 32'h0020_0113);
    if_req = 1'b1;
    if_addr = 32'h0;
    wait_rdy(1'b0);
    tick();
    if_addr = 32'h4;
    wait_rdy(1'b0);
    tick();
    if_addr = 32'h8;
    wait_rdy(1'b0);
    tick();
    if_req = 1'b0;

    for (int i = 0; i < 5; i++) tick();
    chk("gq_left", 32'(gq.size()), 0);
    chk("rq_left", 32'(rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
